// File: rtl/system_pkg.sv
// Shared state encodings, default timing parameters and counter sizing for reset_sequencer.
package system_pkg;

  typedef enum logic [2:0] {
    ST_HOLD       = 3'd0,
    ST_REL_BUS    = 3'd1,
    ST_REL_CORE   = 3'd2,
    ST_REL_PERIPH = 3'd3,
    ST_RUN        = 3'd4,
    ST_FAULT      = 3'd5
  } seq_state_e;

  localparam int unsigned DEF_HOLD_CYCLES  = 16;
  localparam int unsigned DEF_STAGE_GAP    = 8;
  localparam int unsigned DEF_INIT_TIMEOUT = 1024;
  localparam int unsigned DEF_WDT_CYCLES   = 65536;

  // One width serves every counter: enough bits for the largest terminal count plus headroom.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle of reset_sequencer; master drives the inputs, slave is the sequencer.
interface reset_sequencer_if;
  // locked is a level from another clock domain; sw_reset_req and wdt_kick are one-cycle
  // pulses; periph_init_done is a clk_sys level; all outputs are registered levels.
  logic       locked;
  logic       sw_reset_req;
  logic       periph_init_done;
  logic       wdt_kick;
  logic       rst_bus_n;
  logic       rst_core_n;
  logic       rst_periph_n;
  logic       sys_ready;
  logic [2:0] state;
  logic       init_timeout;
  logic       wdt_expired;

  modport master (
    output locked, sw_reset_req, periph_init_done, wdt_kick,
    input  rst_bus_n, rst_core_n, rst_periph_n, sys_ready, state, init_timeout, wdt_expired
  );

  modport slave (
    input  locked, sw_reset_req, periph_init_done, wdt_kick,
    output rst_bus_n, rst_core_n, rst_periph_n, sys_ready, state, init_timeout, wdt_expired
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops clear on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release (bus, core, peripheral) gated on a stable clock lock.
// Optional watchdog in RUN is enabled by defining WATCHDOG_EN.
module reset_sequencer
  import system_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned STAGE_GAP    = DEF_STAGE_GAP,
  parameter int unsigned INIT_TIMEOUT = DEF_INIT_TIMEOUT,
  parameter int unsigned WDT_CYCLES   = DEF_WDT_CYCLES
) (
  input  logic             clk_sys,
  input  logic             reset_sys_n,
  reset_sequencer_if.slave ctrl_if
);

  localparam int unsigned      CNT_W     = cnt_width(HOLD_CYCLES, STAGE_GAP, INIT_TIMEOUT, WDT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_bus_n_q, rst_bus_n_d;
  logic             rst_core_n_q, rst_core_n_d;
  logic             rst_periph_n_q, rst_periph_n_d;
  logic             sys_ready_q, sys_ready_d;
  logic             init_timeout_q, init_timeout_d;
  logic             locked_sync;

  sync_2ff u_lock_sync (
    .clk   (clk_sys),
    .rst_n (reset_sys_n),
    .d_i   (ctrl_if.locked),
    .q_o   (locked_sync)
  );

`ifdef WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDT_LAST = CNT_W'(WDT_CYCLES - 1);

  logic [CNT_W-1:0] wdt_q, wdt_d;
  logic             wdt_expired_q, wdt_expired_d;
  logic             wdt_fire;

  assign wdt_fire = (state_q == ST_RUN) && !ctrl_if.wdt_kick && (wdt_q == WDT_LAST);

  always_comb begin
    wdt_expired_d = wdt_expired_q;
    wdt_d         = '0;
    if (wdt_fire) wdt_expired_d = 1'b1;
    if (ctrl_if.sw_reset_req) wdt_expired_d = 1'b0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !ctrl_if.wdt_kick) wdt_d = sat_inc(wdt_q);
  end

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      wdt_q         <= '0;
      wdt_expired_q <= 1'b0;
    end else begin
      wdt_q         <= wdt_d;
      wdt_expired_q <= wdt_expired_d;
    end
  end

  assign ctrl_if.wdt_expired = wdt_expired_q;
`else
  logic wdt_fire;
  assign wdt_fire            = 1'b0;
  assign ctrl_if.wdt_expired = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = sat_inc(cnt_q);
    init_timeout_d = init_timeout_q;

    case (state_q)
      ST_HOLD:       if (cnt_q == HOLD_LAST) state_d = ST_REL_BUS;
      ST_REL_BUS:    if (cnt_q == GAP_LAST)  state_d = ST_REL_CORE;
      ST_REL_CORE:   if (cnt_q == GAP_LAST)  state_d = ST_REL_PERIPH;
      ST_REL_PERIPH: begin
        if (ctrl_if.periph_init_done) begin
          state_d = ST_RUN;
        end else if (cnt_q == INIT_LAST) begin
          state_d        = ST_FAULT;
          init_timeout_d = 1'b1;
        end
      end
      ST_RUN:        if (wdt_fire) state_d = ST_HOLD;
      ST_FAULT:      state_d = ST_FAULT;
      default:       state_d = ST_HOLD;
    endcase

    // Software request, then lock loss, override the normal flow; both restart the hold count.
    if (ctrl_if.sw_reset_req) begin
      state_d        = ST_HOLD;
      cnt_d          = '0;
      init_timeout_d = 1'b0;
    end
    if (!locked_sync) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end
    if (state_d != state_q) cnt_d = '0;

    rst_bus_n_d    = (state_d != ST_HOLD);
    rst_core_n_d   = (state_d == ST_REL_CORE) || (state_d == ST_REL_PERIPH) ||
                     (state_d == ST_RUN)      || (state_d == ST_FAULT);
    rst_periph_n_d = (state_d == ST_REL_PERIPH) || (state_d == ST_RUN);
    sys_ready_d    = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_sys or negedge reset_sys_n) begin
    if (!reset_sys_n) begin
      state_q        <= ST_HOLD;
      cnt_q          <= '0;
      rst_bus_n_q    <= 1'b0;
      rst_core_n_q   <= 1'b0;
      rst_periph_n_q <= 1'b0;
      sys_ready_q    <= 1'b0;
      init_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rst_bus_n_q    <= rst_bus_n_d;
      rst_core_n_q   <= rst_core_n_d;
      rst_periph_n_q <= rst_periph_n_d;
      sys_ready_q    <= sys_ready_d;
      init_timeout_q <= init_timeout_d;
    end
  end

  assign ctrl_if.rst_bus_n    = rst_bus_n_q;
  assign ctrl_if.rst_core_n   = rst_core_n_q;
  assign ctrl_if.rst_periph_n = rst_periph_n_q;
  assign ctrl_if.sys_ready    = sys_ready_q;
  assign ctrl_if.state        = state_q;
  assign ctrl_if.init_timeout = init_timeout_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Table-driven bench for reset_sequencer with small timing parameters; define WATCHDOG_EN
// for both files to exercise the watchdog rows.
module tb_reset_sequencer;

  // Observed vector: {state[2:0], rst_bus_n, rst_core_n, rst_periph_n, sys_ready, init_timeout, wdt_expired}
  localparam logic [8:0] E_HOLD     = {3'd0, 4'b0000, 2'b00};
  localparam logic [8:0] E_BUS      = {3'd1, 4'b1000, 2'b00};
  localparam logic [8:0] E_CORE     = {3'd2, 4'b1100, 2'b00};
  localparam logic [8:0] E_PER      = {3'd3, 4'b1110, 2'b00};
  localparam logic [8:0] E_RUN      = {3'd4, 4'b1111, 2'b00};
  localparam logic [8:0] E_FAULT    = {3'd5, 4'b1100, 2'b10};
  localparam logic [8:0] E_HOLD_WDT = {3'd0, 4'b0000, 2'b01};

  logic clk_sys     = 1'b0;
  logic reset_sys_n = 1'b0;

  reset_sequencer_if ctrl_if ();

  reset_sequencer #(
    .HOLD_CYCLES  (4),
    .STAGE_GAP    (2),
    .INIT_TIMEOUT (10),
    .WDT_CYCLES   (32)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_sys_n (reset_sys_n),
    .ctrl_if     (ctrl_if)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string      name;
    logic       lk;
    logic       sw;
    logic       done;
    logic       kick;
    int         n;
    logic [8:0] exp;
  } row_t;

  row_t       tbl[$];
  logic [8:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [8:0] observe();
    return {ctrl_if.state, ctrl_if.rst_bus_n, ctrl_if.rst_core_n, ctrl_if.rst_periph_n,
            ctrl_if.sys_ready, ctrl_if.init_timeout, ctrl_if.wdt_expired};
  endfunction

  function automatic void add(input string name, input logic lk, input logic sw, input logic done,
                              input logic kick, input int n, input logic [8:0] exp);
    row_t r;
    r.name = name; r.lk = lk; r.sw = sw; r.done = done; r.kick = kick; r.n = n; r.exp = exp;
    tbl.push_back(r);
  endfunction

  // Lock held, no init done until the peripheral stage, then two cycles of RUN.
  function automatic void add_release(input string tag, input int hold_n);
    add({tag, "_hold"}, 1'b1, 1'b0, 1'b0, 1'b0, hold_n, E_HOLD);
    add({tag, "_bus"},  1'b1, 1'b0, 1'b0, 1'b0, 2,      E_BUS);
    add({tag, "_core"}, 1'b1, 1'b0, 1'b0, 1'b0, 2,      E_CORE);
    add({tag, "_per"},  1'b1, 1'b0, 1'b0, 1'b0, 1,      E_PER);
    add({tag, "_run"},  1'b1, 1'b0, 1'b1, 1'b0, 2,      E_RUN);
  endfunction

  task automatic compare_pop(input string name);
    logic [8:0] exp;
    logic [8:0] got;
    exp = exp_q.pop_front();
    got = observe();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input row_t r);
    ctrl_if.locked           = r.lk;
    ctrl_if.sw_reset_req     = r.sw;
    ctrl_if.periph_init_done = r.done;
    ctrl_if.wdt_kick         = r.kick;
    exp_q.push_back(r.exp);
    @(posedge clk_sys);
    #1;
    compare_pop(r.name);
  endtask

  task automatic run_rows();
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) step(tbl[i]);
    end
    tbl.delete();
  endtask

  initial begin
    ctrl_if.locked           = 1'b1;
    ctrl_if.sw_reset_req     = 1'b0;
    ctrl_if.periph_init_done = 1'b0;
    ctrl_if.wdt_kick         = 1'b0;

    #12;
    exp_q.push_back(E_HOLD);
    compare_pop("reset_state");
    @(posedge clk_sys);
    #1;
    reset_sys_n = 1'b1;

    // Power-up: two sync cycles plus four counted lock cycles before the bus release.
    add_release("pwr", 5);

`ifdef WATCHDOG_EN
    for (int k = 0; k < 3; k++) begin
      add("wdt_kick", 1'b1, 1'b0, 1'b1, 1'b1, 1,  E_RUN);
      add("wdt_keep", 1'b1, 1'b0, 1'b1, 1'b0, 19, E_RUN);
    end
    add("wdt_last",  1'b1, 1'b0, 1'b1, 1'b1, 1,  E_RUN);
    add("wdt_count", 1'b1, 1'b0, 1'b1, 1'b0, 31, E_RUN);
    add("wdt_fire",  1'b1, 1'b0, 1'b1, 1'b0, 1,  E_HOLD_WDT);
    add("wdt_clr",   1'b1, 1'b1, 1'b0, 1'b0, 1,  E_HOLD);
    add_release("wdt_re", 3);
`else
    add("nowdt_kick", 1'b1, 1'b0, 1'b1, 1'b1, 1,  E_RUN);
    add("nowdt_run",  1'b1, 1'b0, 1'b1, 1'b0, 40, E_RUN);
`endif

    // Lock loss in RUN is seen through the two-flop synchronizer.
    add("lock_lag",  1'b0, 1'b0, 1'b1, 1'b0, 2, E_RUN);
    add("lock_hold", 1'b0, 1'b0, 1'b0, 1'b0, 3, E_HOLD);

    // One-cycle lock glitch during HOLD: release comes four lock cycles after the glitch.
    add("glitch_pre",  1'b1, 1'b0, 1'b0, 1'b0, 2,  E_HOLD);
    add("glitch",      1'b0, 1'b0, 1'b0, 1'b0, 1,  E_HOLD);
    add("glitch_post", 1'b1, 1'b0, 1'b0, 1'b0, 5,  E_HOLD);
    add("glitch_bus",  1'b1, 1'b0, 1'b0, 1'b0, 2,  E_BUS);
    add("glitch_core", 1'b1, 1'b0, 1'b0, 1'b0, 2,  E_CORE);
    add("init_wait",   1'b1, 1'b0, 1'b0, 1'b0, 10, E_PER);
    add("init_fault",  1'b1, 1'b0, 1'b0, 1'b0, 3,  E_FAULT);
    add("fault_sw",    1'b1, 1'b1, 1'b0, 1'b0, 1,  E_HOLD);
    add_release("post_fault", 3);

    // Lock drop and software request in the same RUN cycle.
    add("drop_sw",    1'b0, 1'b1, 1'b1, 1'b0, 1, E_HOLD);
    add("drop_after", 1'b0, 1'b0, 1'b0, 1'b0, 4, E_HOLD);
    add_release("relock", 5);
    run_rows();

    // Drive into REL_CORE, then assert the asynchronous reset between clock edges.
    add("to_hold",  1'b1, 1'b1, 1'b0, 1'b0, 1, E_HOLD);
    add("pre_hold", 1'b1, 1'b0, 1'b0, 1'b0, 3, E_HOLD);
    add("pre_bus",  1'b1, 1'b0, 1'b0, 1'b0, 2, E_BUS);
    add("pre_core", 1'b1, 1'b0, 1'b0, 1'b0, 1, E_CORE);
    run_rows();
    #3;
    reset_sys_n = 1'b0;
    #1;
    exp_q.push_back(E_HOLD);
    compare_pop("arst_immediate");
    @(posedge clk_sys);
    #1;
    exp_q.push_back(E_HOLD);
    compare_pop("arst_held");
    reset_sys_n = 1'b1;

    // Full sequence again; a software request in HOLD restarts the hold count.
    add("arst_hold",    1'b1, 1'b0, 1'b0, 1'b0, 4, E_HOLD);
    add("sw_in_hold",   1'b1, 1'b1, 1'b0, 1'b0, 1, E_HOLD);
    add("hold_restart", 1'b1, 1'b0, 1'b0, 1'b0, 3, E_HOLD);
    add("arst_bus",     1'b1, 1'b0, 1'b0, 1'b0, 2, E_BUS);
    add("arst_core",    1'b1, 1'b0, 1'b0, 1'b0, 2, E_CORE);
    add("arst_per",     1'b1, 1'b0, 1'b0, 1'b0, 1, E_PER);
    add("arst_run",     1'b1, 1'b0, 1'b1, 1'b0, 2, E_RUN);
    run_rows();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
